// File: rtl/wb_timer_intc_pkg.sv
// Shared constants and helpers for the Wishbone timer/interrupt controller:
// register map, CTRL bit positions, CPU interrupt codes.
package wb_timer_intc_pkg;

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;
  localparam logic [2:0] REG_COUNT0 = 3'd2;
  localparam logic [2:0] REG_CMP0   = 3'd3;
  localparam logic [2:0] REG_COUNT1 = 3'd4;
  localparam logic [2:0] REG_CMP1   = 3'd5;
  localparam logic [2:0] REG_SWI    = 3'd6;

  localparam int CTRL_EN0     = 0;
  localparam int CTRL_EN1     = 1;
  localparam int CTRL_RL0     = 2;
  localparam int CTRL_RL1     = 3;
  localparam int CTRL_IRQ_LSB = 4;

  localparam logic [2:0] INT_NONE = 3'h0;
  localparam logic [2:0] INT_T0   = 3'h1;
  localparam logic [2:0] INT_T1   = 3'h2;
  localparam logic [2:0] INT_SW   = 3'h3;

  function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  sel);
    logic [31:0] r;
    r = old_val;
    for (int b = 0; b < 4; b++)
      if (sel[b]) r[8*b +: 8] = new_val[8*b +: 8];
    return r;
  endfunction

  // Active sources ordered {sw, t1, t0}; timer 0 has the highest priority.
  function automatic logic [2:0] int_encode(input logic [2:0] act);
    if (act[0])      return INT_T0;
    else if (act[1]) return INT_T1;
    else if (act[2]) return INT_SW;
    else             return INT_NONE;
  endfunction

endpackage

// File: rtl/wb_timer_intc_if.sv
// Wishbone classic bus bundle between the bexkat1p data-bus decoder and
// the timer/interrupt controller.
interface wb_timer_intc_if;
  logic        cyc_i;
  logic        stb_i;
  logic        we_i;
  logic [3:0]  sel_i;
  logic [2:0]  adr_i;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        ack_o;

  modport master (output cyc_i, stb_i, we_i, sel_i, adr_i, dat_i,
                  input  dat_o, ack_o);
  modport slave  (input  cyc_i, stb_i, we_i, sel_i, adr_i, dat_i,
                  output dat_o, ack_o);
endinterface

// File: rtl/wb_timer_intc_timer_chan.sv
// One compare-match timer channel: COUNT/CMP registers with byte-lane writes,
// tick-driven increment, match detection and optional auto-reload.
module timer_chan
  import wb_timer_intc_pkg::*;
#(
  parameter int CWIDTH = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              tick,
  input  logic              en,
  input  logic              reload,
  input  logic              wr_count,
  input  logic              wr_cmp,
  input  logic [3:0]        sel,
  input  logic [31:0]       wdata,
  output logic [CWIDTH-1:0] count,
  output logic [CWIDTH-1:0] cmp,
  output logic              pend_set,
  output logic              en_clr
);

  logic step;
  logic match;

  assign step     = tick && en;
  assign match    = step && (count == cmp);
  assign pend_set = match;
  assign en_clr   = match && !reload;

  // A bus write to COUNT on a tick edge takes precedence over the tick update.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count <= '0;
      cmp   <= '0;
    end else begin
      if (wr_count)
        count <= CWIDTH'(lane_merge(32'(count), wdata, sel));
      else if (step) begin
        if (!match)
          count <= count + CWIDTH'(1);
        else if (reload)
          count <= '0;
      end
      if (wr_cmp)
        cmp <= CWIDTH'(lane_merge(32'(cmp), wdata, sel));
    end
  end

endmodule

// File: rtl/wb_timer_intc.sv
// Wishbone classic timer/interrupt controller: two compare-match timers and a
// software interrupt, priority-encoded onto the CPU's 3-bit interrupt input.
module wb_timer_intc
  import wb_timer_intc_pkg::*;
#(
  parameter int PRESCALE = 1,
  parameter int CWIDTH   = 32
) (
  input  logic           clk_i,
  input  logic           rst_i,
  wb_timer_intc_if.slave wb,
  output logic [2:0]     inter_o
);

  localparam int             PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]  PSC_LAST = PW'(PRESCALE - 1);

  logic              accept, wr, run, tick;
  logic [PW-1:0]     psc;
  logic [6:0]        ctrl;
  logic [2:0]        pend, pend_set, w1c;
  logic [CWIDTH-1:0] count0, cmp0, count1, cmp1;
  logic              set0, set1, clr0, clr1;
  logic [31:0]       rdata;

  assign accept = wb.cyc_i & wb.stb_i & ~wb.ack_o;
  assign wr     = accept & wb.we_i;
  assign run    = ctrl[CTRL_EN0] | ctrl[CTRL_EN1];
  assign tick   = run && (psc == PSC_LAST);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)           psc <= '0;
    else if (!run || tick) psc <= '0;
    else                  psc <= psc + PW'(1);
  end

  timer_chan #(.CWIDTH(CWIDTH)) u_chan0 (
    .clk_i(clk_i), .rst_i(rst_i), .tick(tick),
    .en(ctrl[CTRL_EN0]), .reload(ctrl[CTRL_RL0]),
    .wr_count(wr && wb.adr_i == REG_COUNT0), .wr_cmp(wr && wb.adr_i == REG_CMP0),
    .sel(wb.sel_i), .wdata(wb.dat_i),
    .count(count0), .cmp(cmp0), .pend_set(set0), .en_clr(clr0)
  );

  timer_chan #(.CWIDTH(CWIDTH)) u_chan1 (
    .clk_i(clk_i), .rst_i(rst_i), .tick(tick),
    .en(ctrl[CTRL_EN1]), .reload(ctrl[CTRL_RL1]),
    .wr_count(wr && wb.adr_i == REG_COUNT1), .wr_cmp(wr && wb.adr_i == REG_CMP1),
    .sel(wb.sel_i), .wdata(wb.dat_i),
    .count(count1), .cmp(cmp1), .pend_set(set1), .en_clr(clr1)
  );

  // Set sources win over write-one-to-clear on the same edge.
  assign pend_set = {wr && (wb.adr_i == REG_SWI) && wb.sel_i[0] && wb.dat_i[0], set1, set0};
  assign w1c      = (wr && (wb.adr_i == REG_STATUS) && wb.sel_i[0]) ? wb.dat_i[2:0] : 3'b000;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ctrl <= '0;
      pend <= '0;
    end else begin
      if (wr && (wb.adr_i == REG_CTRL) && wb.sel_i[0])
        ctrl <= wb.dat_i[6:0];
      else begin
        if (clr0) ctrl[CTRL_EN0] <= 1'b0;
        if (clr1) ctrl[CTRL_EN1] <= 1'b0;
      end
      pend <= (pend & ~w1c) | pend_set;
    end
  end

  always_comb begin
    rdata = '0;
    case (wb.adr_i)
      REG_CTRL:   rdata = {25'd0, ctrl};
      REG_STATUS: rdata = {29'd0, pend};
      REG_COUNT0: rdata = 32'(count0);
      REG_CMP0:   rdata = 32'(cmp0);
      REG_COUNT1: rdata = 32'(count1);
      REG_CMP1:   rdata = 32'(cmp1);
      default:    rdata = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wb.ack_o <= 1'b0;
      wb.dat_o <= '0;
      inter_o  <= INT_NONE;
    end else begin
      wb.ack_o <= accept;
      if (accept) wb.dat_o <= rdata;
      inter_o <= int_encode(pend & ctrl[CTRL_IRQ_LSB +: 3]);
    end
  end

endmodule

// File: tb/tb_wb_timer_intc.sv
// Scoreboard bench for wb_timer_intc: bus accesses queue their expected read
// data, a negedge monitor compares on every ack from either DUT instance.
module tb_wb_timer_intc;
  import wb_timer_intc_pkg::*;

  typedef struct {
    logic        chk;
    logic [31:0] exp;
    string       nm;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] inter0, inter1;
  exp_t       sbq[$];
  int         n_chk = 0;
  int         n_fail = 0;

  wb_timer_intc_if bus0();
  wb_timer_intc_if bus1();

  wb_timer_intc #(.PRESCALE(1), .CWIDTH(32)) dut0 (
    .clk_i(clk), .rst_i(rst_n), .wb(bus0), .inter_o(inter0));
  wb_timer_intc #(.PRESCALE(4), .CWIDTH(32)) dut1 (
    .clk_i(clk), .rst_i(rst_n), .wb(bus1), .inter_o(inter1));

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic sb_pop(input logic [31:0] dat);
    exp_t e;
    if (sbq.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL unexpected_ack: got ack with data %h, expected no ack", dat);
    end else begin
      e = sbq.pop_front();
      if (e.chk) check(e.nm, dat, e.exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus0.ack_o) sb_pop(bus0.dat_o);
      if (bus1.ack_o) sb_pop(bus1.dat_o);
    end
  end

  task automatic drive(input int d, input logic cs, input logic we, input logic [2:0] adr,
                       input logic [31:0] wd, input logic [3:0] sel);
    if (d == 0) begin
      bus0.cyc_i = cs; bus0.stb_i = cs; bus0.we_i = we;
      bus0.adr_i = adr; bus0.dat_i = wd; bus0.sel_i = sel;
    end else begin
      bus1.cyc_i = cs; bus1.stb_i = cs; bus1.we_i = we;
      bus1.adr_i = adr; bus1.dat_i = wd; bus1.sel_i = sel;
    end
  endtask

  // Call at a negedge; returns at the negedge where ack is seen.
  task automatic bus_op(input int d, input logic we, input logic [2:0] adr,
                        input logic [31:0] wd, input logic [3:0] sel,
                        input logic [31:0] exp, input string nm);
    exp_t e;
    int   n;
    logic acked;
    e.chk = !we; e.exp = exp; e.nm = nm;
    sbq.push_back(e);
    drive(d, 1'b1, we, adr, wd, sel);
    n = 0;
    acked = 1'b0;
    while (!acked && n < 8) begin
      @(negedge clk);
      n++;
      acked = (d == 0) ? bus0.ack_o : bus1.ack_o;
    end
    drive(d, 1'b0, 1'b0, 3'd0, 32'd0, 4'd0);
    if (!acked) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: got no ack in 8 cycles, expected ack", nm);
    end
  endtask

  task automatic wr(input int d, input logic [2:0] adr, input logic [31:0] wd);
    bus_op(d, 1'b1, adr, wd, 4'hF, 32'd0, "write");
  endtask

  task automatic rd(input int d, input logic [2:0] adr, input logic [31:0] exp, input string nm);
    bus_op(d, 1'b0, adr, 32'd0, 4'h0, exp, nm);
  endtask

  initial begin
    int   acks;
    exp_t e;
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 3'd0, 32'd0, 4'd0);
    drive(1, 1'b0, 1'b0, 3'd0, 32'd0, 4'd0);
    repeat (3) @(negedge clk);
    check("rst_ack", {31'd0, bus0.ack_o}, 32'd0);
    check("rst_inter", {29'd0, inter0}, 32'd0);
    check("rst_dat", bus0.dat_o, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int a = 0; a < 8; a++) rd(0, 3'(a), 32'd0, "reset_reg");

    // Reset asserted while ack is high
    wr(0, REG_CTRL, 32'h70);
    wr(0, REG_SWI, 32'h1);
    @(negedge clk);
    check("swi_inter", {29'd0, inter0}, 32'h3);
    rd(0, REG_STATUS, 32'h4, "swi_status");
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ack", {31'd0, bus0.ack_o}, 32'd0);
    check("midrst_inter", {29'd0, inter0}, 32'd0);
    check("midrst_dat", bus0.dat_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd(0, REG_CTRL, 32'd0, "post_rst_ctrl");
    rd(0, REG_STATUS, 32'd0, "post_rst_status");

    // Byte lanes and held cyc/stb
    bus_op(0, 1'b1, REG_CMP0, 32'h12345678, 4'b0101, 32'd0, "write_sel");
    rd(0, REG_CMP0, 32'h00340078, "sel_merge");
    @(negedge clk);
    e.chk = 1'b1; e.exp = 32'h00340078; e.nm = "held_read";
    repeat (3) sbq.push_back(e);
    drive(0, 1'b1, 1'b0, REG_CMP0, 32'd0, 4'd0);
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) check("ack_first", {31'd0, bus0.ack_o}, 32'd1);
      if (i == 1) check("ack_single", {31'd0, bus0.ack_o}, 32'd0);
      if (bus0.ack_o) acks++;
    end
    drive(0, 1'b0, 1'b0, 3'd0, 32'd0, 4'd0);
    check("held_ack_count", acks, 32'd3);

    // One-shot timer 0
    wr(0, REG_CMP0, 32'd5);
    wr(0, REG_CTRL, 32'h011);
    repeat (6) @(negedge clk);
    check("oneshot_lag", {29'd0, inter0}, 32'd0);
    @(negedge clk);
    check("oneshot_inter", {29'd0, inter0}, {29'd0, INT_T0});
    rd(0, REG_CTRL, 32'h010, "oneshot_ctrl");
    rd(0, REG_COUNT0, 32'd5, "oneshot_count");
    rd(0, REG_STATUS, 32'h1, "oneshot_status");
    wr(0, REG_STATUS, 32'h1);
    @(negedge clk);
    check("w1c_inter", {29'd0, inter0}, 32'd0);
    rd(0, REG_STATUS, 32'h0, "w1c_status");

    // Reload and priority
    wr(0, REG_CMP0, 32'd3);
    wr(0, REG_CMP1, 32'd3);
    wr(0, REG_COUNT0, 32'd0);
    wr(0, REG_CTRL, 32'h07f);
    repeat (3) @(negedge clk);
    wr(0, REG_CTRL, 32'h070);
    rd(0, REG_COUNT0, 32'd0, "reload_count0");
    rd(0, REG_COUNT1, 32'd0, "reload_count1");
    rd(0, REG_STATUS, 32'h3, "reload_status");
    wr(0, REG_SWI, 32'h1);
    rd(0, REG_STATUS, 32'h7, "all_pend");
    @(negedge clk);
    check("prio_t0", {29'd0, inter0}, {29'd0, INT_T0});
    wr(0, REG_STATUS, 32'h1);
    @(negedge clk);
    check("prio_t1", {29'd0, inter0}, {29'd0, INT_T1});
    wr(0, REG_STATUS, 32'h2);
    @(negedge clk);
    check("prio_sw", {29'd0, inter0}, {29'd0, INT_SW});
    wr(0, REG_CTRL, 32'h000);
    @(negedge clk);
    check("mask_inter", {29'd0, inter0}, 32'd0);
    rd(0, REG_STATUS, 32'h4, "mask_keeps_pend");
    wr(0, REG_STATUS, 32'h4);

    // W1C on the match edge loses to the hardware set
    wr(0, REG_CMP0, 32'd2);
    wr(0, REG_COUNT0, 32'd0);
    wr(0, REG_CTRL, 32'h011);
    repeat (2) @(negedge clk);
    wr(0, REG_STATUS, 32'h1);
    rd(0, REG_STATUS, 32'h1, "collide_w1c");
    rd(0, REG_CTRL, 32'h010, "collide_ctrl");
    wr(0, REG_STATUS, 32'h1);
    rd(0, REG_STATUS, 32'h0, "collide_cleared");

    // COUNT write on a tick edge wins, then counting resumes
    wr(0, REG_CMP0, 32'h0000FFFF);
    wr(0, REG_COUNT0, 32'd0);
    wr(0, REG_CTRL, 32'h001);
    wr(0, REG_COUNT0, 32'h100);
    rd(0, REG_COUNT0, 32'h101, "collide_count");
    wr(0, REG_CTRL, 32'h000);

    // Wrap and prescale on the PRESCALE=4 instance
    wr(1, REG_COUNT1, 32'hFFFFFFFF);
    wr(1, REG_CMP1, 32'd1);
    wr(1, REG_CTRL, 32'h022);
    repeat (3) @(negedge clk);
    rd(1, REG_COUNT1, 32'hFFFFFFFF, "psc_before_tick");
    rd(1, REG_COUNT1, 32'h0, "psc_wrap");
    repeat (6) @(negedge clk);
    check("psc_no_pend", {29'd0, inter1}, 32'd0);
    @(negedge clk);
    check("psc_inter", {29'd0, inter1}, {29'd0, INT_T1});
    rd(1, REG_STATUS, 32'h2, "psc_status");
    rd(1, REG_COUNT1, 32'h1, "psc_count_hold");
    rd(1, REG_CTRL, 32'h020, "psc_ctrl");

    repeat (4) @(negedge clk);
    check("sb_empty", sbq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
